// File: rtl/spi_byte_master.sv
// spi_byte_master -- single-byte SPI master, mode 0 (SCK idles low, MOSI
// changes on the falling edge, MISO sampled on the rising edge), MSB first.
//
// Ports:
//   clk      system clock, all state changes on its rising edge
//   reset_n  synchronous active-low reset (wins over ce)
//   ce       clock enable; with ce=0 every register holds
//   idata    byte to send, captured when iwr is accepted in IDLE
//   iwr      one-ce-cycle transfer request; ignored while obusy=1
//   idiv     SCK half period minus one, in ce cycles, captured with iwr
//   ics      chip-select request (1 = select), registered onto cs_n
//   odata    last received byte, valid from the odsr cycle onward
//   odsr     one-ce-cycle pulse per completed byte
//   obusy    transfer in progress (accept cycle + 1 through the odsr cycle)
//   sck      SPI clock
//   mosi     SPI data out (always shift register bit 7)
//   miso     SPI data in
//   cs_n     SPI chip select, active low
module spi_byte_master #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [7:0]       idata,
  input  logic             iwr,
  input  logic [DIV_W-1:0] idiv,
  input  logic             ics,
  output logic [7:0]       odata,
  output logic             odsr,
  output logic             obusy,
  output logic             sck,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [7:0]       odata_q, odata_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             cap_q, cap_d;
  logic             sck_q, sck_d;
  logic             odsr_q, odsr_d;
  logic             busy_q, busy_d;
  logic             cs_n_q;
  logic             phase_end;

  // A half period ends when the counter reaches the divider latched at
  // the start of the transfer, so idiv may change freely meanwhile.
  assign phase_end = (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    odata_d = odata_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cap_d   = cap_q;
    sck_d   = sck_q;
    odsr_d  = odsr_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (iwr) begin
          sreg_d  = idata;
          div_d   = idiv;
          cnt_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end

      LOW: begin
        if (phase_end) begin
          cnt_d   = '0;
          cap_d   = miso;          // rising SCK edge: sample MISO
          sck_d   = 1'b1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HIGH: begin
        if (phase_end) begin
          cnt_d  = '0;
          sck_d  = 1'b0;            // falling edge: next bit onto MOSI
          sreg_d = {sreg_q[6:0], cap_q};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            // Load odata together with the last shift so that odata is
            // already valid in the cycle odsr is high.
            odata_d = {sreg_q[6:0], cap_q};
            odsr_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // iwr is deliberately not looked at here: no queuing.
        odsr_d  = 1'b0;
        busy_d  = 1'b0;
        sreg_d  = 8'hFF;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q  <= 8'hFF;
      odata_q <= 8'hFF;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      cap_q   <= 1'b0;
      sck_q   <= 1'b0;
      odsr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      odata_q <= odata_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cap_q   <= cap_d;
      sck_q   <= sck_d;
      odsr_q  <= odsr_d;
      busy_q  <= busy_d;
    end
  end

  // Chip select follows ics independently of the transfer state machine.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_n_q <= 1'b1;
    end else if (ce) begin
      cs_n_q <= ~ics;
    end
  end

  assign odata = odata_q;
  assign odsr  = odsr_q;
  assign obusy = busy_q;
  assign sck   = sck_q;
  assign mosi  = sreg_q[7];
  assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Testbench for spi_byte_master: table of transfers plus hand-written
// sequences for ignored requests, ce gating, mid-transfer reset and a
// long back-to-back stream. Expected bytes are queued when a request is
// driven and compared when odsr is seen.
module tb_spi_byte_master;

  logic       clk;
  logic       reset_n, ce, iwr, ics;
  logic [7:0] idata, idiv;
  logic [7:0] odata;
  logic       odsr, obusy, sck, mosi, cs_n;
  logic       miso;
  logic [1:0] miso_mode;   // 0: const 0, 1: const 1, 2: loopback, 3: inverted loopback

  assign miso = (miso_mode == 2'd2) ? mosi :
                (miso_mode == 2'd3) ? ~mosi : miso_mode[0];

  spi_byte_master #(.DIV_W(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ce     (ce),
    .idata  (idata),
    .iwr    (iwr),
    .idiv   (idiv),
    .ics    (ics),
    .odata  (odata),
    .odsr   (odsr),
    .obusy  (obusy),
    .sck    (sck),
    .mosi   (mosi),
    .miso   (miso),
    .cs_n   (cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] div;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         ce_cyc = 0;
  int         odsr_cnt = 0;
  int         odsr_clk = 0;
  int         last_odsr_ce = 0;
  int         pulses, high_run, low_run, min_hi, max_hi, min_lo, max_lo, busy_cnt;
  logic       sck_prev;
  logic [7:0] mosi_hist;
  bit         toggle_ce = 0;
  logic [7:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    pulses    = 0;
    high_run  = 0;
    low_run   = 0;
    min_hi    = 1000000;
    max_hi    = 0;
    min_lo    = 1000000;
    max_lo    = 0;
    busy_cnt  = 0;
    odsr_clk  = 0;
    sck_prev  = sck;
    mosi_hist = 8'h00;
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the
  // next rising edge so the caller can drive inputs.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (reset_n && odsr) odsr_clk++;
    if (ce) begin
      ce_cyc++;
      if (obusy) busy_cnt++;
      if (reset_n && odsr) begin
        odsr_cnt++;
        last_odsr_ce = ce_cyc;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL odsr_unexpected odata=%02h required=no_pulse", odata);
        end else begin
          e = sb_q.pop_front();
          chk("odata", {24'd0, odata}, {24'd0, e});
        end
      end
    end
    if (sck) begin
      if (!sck_prev) begin
        if (pulses > 0) begin
          if (low_run < min_lo) min_lo = low_run;
          if (low_run > max_lo) max_lo = low_run;
        end
        pulses++;
        mosi_hist = {mosi_hist[6:0], mosi};
        high_run = 0;
      end
      high_run++;
    end else begin
      if (sck_prev) begin
        if (high_run < min_hi) min_hi = high_run;
        if (high_run > max_hi) max_hi = high_run;
        low_run = 0;
      end
      low_run++;
    end
    sck_prev = sck;
    @(posedge clk);
    #1;
    if (toggle_ce) ce = ~ce;
  endtask

  // Full transfer: strobe, scramble idata/idiv while busy, wait for odsr,
  // then check timing, SCK shape and MOSI bits.
  task automatic do_xfer(input logic [7:0] d, input logic [7:0] div,
                         input logic [1:0] mode, input logic [7:0] exp,
                         input bit phase_chk);
    int n, c0, budget, lat;
    miso_mode = mode;
    idata     = d;
    idiv      = div;
    if (!ce) tick();
    clear_stats();
    c0 = odsr_cnt;
    iwr = 1'b1;
    sb_q.push_back(exp);
    tick();
    iwr   = 1'b0;
    n     = ce_cyc;
    idata = 8'($urandom);
    idiv  = 8'($urandom);
    lat   = 1 + 16 * (int'(div) + 1);
    budget = 2 * lat + 40;
    while (odsr_cnt == c0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("odsr_pulses", odsr_cnt - c0, 1);
    chk("latency", last_odsr_ce - n, lat);
    chk("sck_pulses", pulses, 8);
    chk("mosi_bits", {24'd0, mosi_hist}, {24'd0, d});
    chk("busy_cycles", busy_cnt, lat);
    chk("odsr_width", odsr_clk, toggle_ce ? 2 : 1);
    if (phase_chk) begin
      chk("sck_high_min", min_hi, int'(div) + 1);
      chk("sck_high_max", max_hi, int'(div) + 1);
      chk("sck_low_min", min_lo, int'(div) + 1);
      chk("sck_low_max", max_lo, int'(div) + 1);
    end
    chk("idle_obusy", obusy, 0);
    chk("idle_sck", sck, 0);
    chk("idle_mosi", mosi, 1);
    chk("odata_hold", {24'd0, odata}, {24'd0, exp});
  endtask

  vec_t vecs[6];

  initial begin
    int n, c0;
    logic [7:0] d;
    logic [1:0] m;

    vecs[0] = '{data: 8'hA5, div: 8'd0, mode: 2'd2, exp: 8'hA5};
    vecs[1] = '{data: 8'h00, div: 8'd3, mode: 2'd1, exp: 8'hFF};
    vecs[2] = '{data: 8'h3C, div: 8'd1, mode: 2'd3, exp: 8'hC3};
    vecs[3] = '{data: 8'hFF, div: 8'd2, mode: 2'd0, exp: 8'h00};
    vecs[4] = '{data: 8'h81, div: 8'd0, mode: 2'd2, exp: 8'h81};
    vecs[5] = '{data: 8'h5A, div: 8'd5, mode: 2'd3, exp: 8'hA5};

    reset_n = 1'b0; ce = 1'b0; iwr = 1'b0; ics = 1'b0;
    idata = 8'h00; idiv = 8'h00; miso_mode = 2'd0;
    clear_stats();
    repeat (3) tick();
    chk("rst_sck", sck, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_obusy", obusy, 0);
    chk("rst_odsr", odsr, 0);
    chk("rst_odata", {24'd0, odata}, 32'hFF);
    chk("rst_mosi", mosi, 1);

    reset_n = 1'b1;
    ce = 1'b1;
    tick();
    ics = 1'b1;
    tick();
    chk("cs_n_select", cs_n, 0);
    ce = 1'b0; ics = 1'b0;
    tick();
    chk("cs_n_frozen", cs_n, 0);
    ce = 1'b1;
    tick();
    chk("cs_n_release", cs_n, 1);
    ics = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      do_xfer(vecs[i].data, vecs[i].div, vecs[i].mode, vecs[i].exp, 1'b1);

    // Requests during the transfer and in the DONE cycle are dropped.
    miso_mode = 2'd2; idiv = 8'd0; idata = 8'hA5;
    clear_stats();
    c0 = odsr_cnt;
    iwr = 1'b1;
    sb_q.push_back(8'hA5);
    tick();
    iwr = 1'b0;
    n = ce_cyc;
    while (ce_cyc < n + 4) tick();
    idata = 8'h11; iwr = 1'b1;
    tick();
    iwr = 1'b0;
    while (ce_cyc < n + 16) tick();
    idata = 8'h22; iwr = 1'b1;
    tick();
    iwr = 1'b0;
    chk("ign_odsr_cycle", last_odsr_ce - n, 17);
    chk("ign_odsr_count", odsr_cnt - c0, 1);
    chk("ign_obusy_after", obusy, 0);
    do_xfer(8'h3C, 8'd0, 2'd2, 8'h3C, 1'b1);

    // ce alternating 1/0.
    toggle_ce = 1'b1;
    do_xfer(8'hA5, 8'd0, 2'd2, 8'hA5, 1'b0);
    toggle_ce = 1'b0;
    ce = 1'b1;
    tick();

    // Reset in the middle of a transfer.
    miso_mode = 2'd2; idiv = 8'd0; idata = 8'h3C;
    iwr = 1'b1;
    tick();
    iwr = 1'b0;
    n = ce_cyc;
    while (ce_cyc < n + 8) tick();
    reset_n = 1'b0;
    c0 = odsr_cnt;
    tick();
    chk("abort_sck", sck, 0);
    chk("abort_obusy", obusy, 0);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_odsr", odsr, 0);
    chk("abort_odata", {24'd0, odata}, 32'hFF);
    reset_n = 1'b1;
    repeat (40) tick();
    chk("abort_no_odsr", odsr_cnt - c0, 0);
    do_xfer(8'hC3, 8'd0, 2'd2, 8'hC3, 1'b1);

    // Back-to-back stream of 512 bytes.
    c0 = odsr_cnt;
    for (int i = 0; i < 512; i++) begin
      d = 8'($urandom);
      m = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3;
      do_xfer(d, 8'd0, m, (m == 2'd3) ? ~d : d, 1'b1);
    end
    chk("dma_pulses", odsr_cnt - c0, 512);
    chk("dma_queue_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
